psram_hs_responder: RTL and testbench

Synthesizable stand-in for the PSRAM HS memory interface's user port: accepts `cmd`/`cmd_en`/`addr`/`wr_data`/`data_mask` bursts from a traffic initiator such as `psram_test`, stores them in on-chip block RAM, and returns read bursts on `rd_data`/`rd_data_valid` with fixed latency. It also models `init_calib`. It sits in place of the memory interface in bring-up and simulation tops, so initiators can be checked without the PLL, DDR I/O or external PSRAM.

---
 rtl/psram_rsp_pkg.sv | 13 +
 rtl/psram_hs_responder_if.sv | 26 ++
 rtl/psram_rsp_mem.sv | 26 ++
 rtl/psram_hs_responder.sv | 169 ++++++++++++++++
 tb/tb_psram_hs_responder.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psram_rsp_pkg.sv
// Shared constants and the write-FSM state type for the PSRAM HS responder.
package psram_rsp_pkg;

   localparam int   BURST_BEATS = 4;
   localparam logic CMD_READ    = 1'b0;
   localparam logic CMD_WRITE   = 1'b1;

   typedef enum logic {
      ST_IDLE,
      ST_WBEAT
   } wr_state_e;

endpackage

// File: rtl/psram_hs_responder_if.sv
// User-port bundle between a PSRAM traffic initiator (master) and the responder (slave).
interface psram_hs_responder_if #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 21,
   parameter int MASK_WIDTH = 16
);
   logic                  cmd;
   logic                  cmd_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [MASK_WIDTH-1:0] data_mask;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_data_valid;
   logic                  init_calib;
   logic                  cmd_err;

   modport master (
      output cmd, cmd_en, addr, wr_data, data_mask,
      input  rd_data, rd_data_valid, init_calib, cmd_err
   );

   modport slave (
      input  cmd, cmd_en, addr, wr_data, data_mask,
      output rd_data, rd_data_valid, init_calib, cmd_err
   );
endinterface

// File: rtl/psram_rsp_mem.sv
// Simple dual-port backing store with byte write-enables and a registered read port.
module psram_rsp_mem #(
   parameter int DATA_WIDTH = 128,
   parameter int MASK_WIDTH = 16,
   parameter int AW         = 10
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [MASK_WIDTH-1:0] be_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   logic [DATA_WIDTH-1:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int i = 0; i < MASK_WIDTH; i++) begin
            if (be_i[i]) mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
         end
      end
      if (re_i) rdata_o <= mem_q[raddr_i];
   end
endmodule

// File: rtl/psram_hs_responder.sv
// BSRAM-backed stand-in for the PSRAM HS user port: 4-beat bursts, fixed read latency.
// Defining PSRAM_RSP_ERR_INJ_EN builds a periodic read-data corruption counter.
module psram_hs_responder
   import psram_rsp_pkg::*;
#(
   parameter int DATA_WIDTH   = 128,
   parameter int ADDR_WIDTH   = 21,
   parameter int MASK_WIDTH   = 16,
   parameter int MEM_AW       = 10,
   parameter int INIT_CYCLES  = 64,
   parameter int RD_LATENCY   = 6,
   parameter int CMD_INTERVAL = 14,
   parameter int ERR_PERIOD   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   psram_hs_responder_if.slave  rsp_if
);
   localparam int IDX_W  = MEM_AW - 2;
   localparam int INIT_W = $clog2(INIT_CYCLES + 1);
   localparam int IVL_W  = $clog2(CMD_INTERVAL);
   localparam int PIPE_D = RD_LATENCY - 1;

   logic                  init_q, init_d;
   logic [INIT_W-1:0]     icnt_q, icnt_d;
   logic [IVL_W-1:0]      ival_q, ival_d;
   logic                  cmd_err_q, cmd_err_d;
   wr_state_e             st_q, st_d;
   logic [IDX_W-1:0]      wline_q, wline_d;
   logic [1:0]            wbeat_q, wbeat_d;
   logic                  accept, rd_accept, rd_issue0, flip;
   logic                  mem_we, mem_re;
   logic [MEM_AW-1:0]     mem_widx, mem_ridx;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [PIPE_D-1:0]     rvld_q;
   logic [IDX_W-1:0]      rline_q [PIPE_D];
   logic [IDX_W-1:0]      rcur_q;
   logic [1:0]            rbeat_q;
   logic                  ract_q, mem_vld_q, rd_vld_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  unused_addr;

   assign unused_addr = ^rsp_if.addr[ADDR_WIDTH-1:IDX_W];

   always_comb begin
      icnt_d    = init_q ? icnt_q : icnt_q + 1'b1;
      init_d    = init_q | (icnt_q == INIT_W'(INIT_CYCLES));
      accept    = rsp_if.cmd_en && init_q && (ival_q == '0) && (st_q == ST_IDLE);
      rd_accept = accept && (rsp_if.cmd == CMD_READ);
      // cmd_en is ignored while write beats 1-3 are in flight
      cmd_err_d = rsp_if.cmd_en && (st_q == ST_IDLE) && !accept;
      ival_d    = accept ? IVL_W'(CMD_INTERVAL - 1)
                         : ((ival_q != '0) ? ival_q - 1'b1 : ival_q);
      st_d      = st_q;
      wline_d   = wline_q;
      wbeat_d   = wbeat_q;
      mem_we    = 1'b0;
      mem_widx  = {rsp_if.addr[IDX_W-1:0], 2'b00};
      case (st_q)
         ST_IDLE: begin
            if (accept && (rsp_if.cmd == CMD_WRITE)) begin
               mem_we  = 1'b1;
               wline_d = rsp_if.addr[IDX_W-1:0];
               wbeat_d = 2'd1;
               st_d    = ST_WBEAT;
            end
         end
         ST_WBEAT: begin
            mem_we   = 1'b1;
            mem_widx = {wline_q, wbeat_q};
            wbeat_d  = wbeat_q + 2'd1;
            if (wbeat_q == 2'(BURST_BEATS - 1)) st_d = ST_IDLE;
         end
         default: st_d = ST_IDLE;
      endcase
   end

   // RAM read for beat b is issued RD_LATENCY-1+b cycles after acceptance
   assign rd_issue0 = rvld_q[PIPE_D-1];
   assign mem_re    = rd_issue0 | ract_q;
   assign mem_ridx  = ract_q ? {rcur_q, rbeat_q} : {rline_q[PIPE_D-1], 2'b00};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         init_q    <= 1'b0;
         icnt_q    <= '0;
         ival_q    <= '0;
         cmd_err_q <= 1'b0;
         st_q      <= ST_IDLE;
         rvld_q    <= '0;
         ract_q    <= 1'b0;
         mem_vld_q <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         init_q    <= init_d;
         icnt_q    <= icnt_d;
         ival_q    <= ival_d;
         cmd_err_q <= cmd_err_d;
         st_q      <= st_d;
         rvld_q    <= (rvld_q << 1) | PIPE_D'(rd_accept);
         if (rd_issue0) ract_q <= 1'b1;
         else if (ract_q && (rbeat_q == 2'(BURST_BEATS - 1))) ract_q <= 1'b0;
         mem_vld_q <= mem_re;
         rd_vld_q  <= mem_vld_q;
         if (mem_vld_q) rd_data_q <= mem_rdata ^ {{(DATA_WIDTH-1){1'b0}}, flip};
      end
   end

   always_ff @(posedge clk) begin
      wline_q    <= wline_d;
      wbeat_q    <= wbeat_d;
      rline_q[0] <= rsp_if.addr[IDX_W-1:0];
      for (int k = 1; k < PIPE_D; k++) rline_q[k] <= rline_q[k-1];
      if (rd_issue0) begin
         rcur_q  <= rline_q[PIPE_D-1];
         rbeat_q <= 2'd1;
      end else if (ract_q) begin
         rbeat_q <= rbeat_q + 2'd1;
      end
   end

`ifdef PSRAM_RSP_ERR_INJ_EN
   localparam int ECNT_W = $clog2(ERR_PERIOD);
   logic [ECNT_W-1:0] ecnt_q;
   logic              flip_q;

   // flip_q lines up with the RAM output of beat 0
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ecnt_q <= '0;
         flip_q <= 1'b0;
      end else begin
         flip_q <= 1'b0;
         if (rd_issue0) begin
            if (ecnt_q == ECNT_W'(ERR_PERIOD - 1)) begin
               ecnt_q <= '0;
               flip_q <= 1'b1;
            end else begin
               ecnt_q <= ecnt_q + 1'b1;
            end
         end
      end
   end
   assign flip = flip_q;
`else
   assign flip = (ERR_PERIOD == 0);
`endif

   psram_rsp_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .MASK_WIDTH (MASK_WIDTH),
      .AW         (MEM_AW)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .be_i    (~rsp_if.data_mask),
      .waddr_i (mem_widx),
      .wdata_i (rsp_if.wr_data),
      .re_i    (mem_re),
      .raddr_i (mem_ridx),
      .rdata_o (mem_rdata)
   );

   assign rsp_if.rd_data       = rd_data_q;
   assign rsp_if.rd_data_valid = rd_vld_q;
   assign rsp_if.init_calib    = init_q;
   assign rsp_if.cmd_err       = cmd_err_q;
endmodule

// File: tb/tb_psram_hs_responder.sv
// Directed + randomized bench for psram_hs_responder against a cycle-indexed memory model.
module tb_psram_hs_responder;
   localparam int DW           = 128;
   localparam int AWID         = 21;
   localparam int MW           = 16;
   localparam int MEM_AW       = 10;
   localparam int INIT_CYCLES  = 64;
   localparam int RD_LATENCY   = 6;
   localparam int CMD_INTERVAL = 14;
`ifdef PSRAM_RSP_ERR_INJ_EN
   localparam int ERR_PERIOD   = 4;
`else
   localparam int ERR_PERIOD   = 16;
`endif

   typedef logic [DW-1:0] beat_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   psram_hs_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWID), .MASK_WIDTH(MW)) bus ();

   psram_hs_responder #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AWID), .MASK_WIDTH(MW), .MEM_AW(MEM_AW),
      .INIT_CYCLES(INIT_CYCLES), .RD_LATENCY(RD_LATENCY),
      .CMD_INTERVAL(CMD_INTERVAL), .ERR_PERIOD(ERR_PERIOD)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .rsp_if (bus)
   );

   int    checks = 0;
   int    errors = 0;
   int    cyc;        // index of the last clock edge since reset release (edge 0 = first with rst_n=1)
   int    last_acc;   // edge of the last accepted command
   int    rd_bursts;  // accepted read bursts since reset
   beat_t model [2**MEM_AW];
   beat_t wd [4];
   logic [MW-1:0] wm [4];
   int    lines [5] = '{5, 2, 0, 7, 1};

   task automatic chk(string tag, beat_t obs, beat_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_b(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_edge(int e);
      while (cyc < e - 1) tick();
   endtask

   function automatic int idx(logic [AWID-1:0] a, int b);
      return (int'(a) % (2**(MEM_AW-2))) * 4 + b;
   endfunction

   function automatic bit will_accept(int e);
      return (e > INIT_CYCLES) && (e - last_acc >= CMD_INTERVAL);
   endfunction

   function automatic beat_t rand_beat();
      beat_t r = '0;
      for (int i = 0; i < DW/32; i++) r = (r << 32) | beat_t'($urandom);
      return r;
   endfunction

   function automatic bit flip_burst(int n);
`ifdef PSRAM_RSP_ERR_INJ_EN
      return (n % ERR_PERIOD) == 0;
`else
      return n < 0;
`endif
   endfunction

   task automatic do_reset(int n);
      rst_n = 1'b0;
      bus.cmd_en = 1'b0;
      repeat (n) tick();
      chk_b("rst_valid", bus.rd_data_valid, 1'b0);
      chk_b("rst_init", bus.init_calib, 1'b0);
      chk_b("rst_err", bus.cmd_err, 1'b0);
      chk("rst_rd_data", bus.rd_data, '0);
      rst_n = 1'b1;
      cyc = -1;
      last_acc = -1000;
      rd_bursts = 0;
   endtask

   task automatic do_write(logic [AWID-1:0] a);
      int e = cyc + 1;
      bit acc = will_accept(e);
      bus.cmd_en = 1'b1;
      bus.cmd = 1'b1;
      bus.addr = a;
      for (int b = 0; b < 4; b++) begin
         bus.wr_data = wd[b];
         bus.data_mask = wm[b];
         tick();
         if (acc) for (int j = 0; j < MW; j++)
            if (!wm[b][j]) model[idx(a, b)][j*8 +: 8] = wd[b][j*8 +: 8];
         if (b == 0) begin
            bus.cmd_en = 1'b0;
            chk_b("wr_cmd_err", bus.cmd_err, !acc);
         end
         if (b == 1) chk_b("wr_cmd_err_clr", bus.cmd_err, 1'b0);
      end
      if (acc) last_acc = e;
   endtask

   task automatic do_read(logic [AWID-1:0] a);
      int e = cyc + 1;
      bit acc = will_accept(e);
      bit flp;
      beat_t exp;
      bus.cmd_en = 1'b1;
      bus.cmd = 1'b0;
      bus.addr = a;
      tick();
      bus.cmd_en = 1'b0;
      chk_b("rd_cmd_err", bus.cmd_err, !acc);
      if (!acc) begin
         tick();
         chk_b("rd_cmd_err_clr", bus.cmd_err, 1'b0);
         chk_b("rd_drop_valid", bus.rd_data_valid, 1'b0);
      end else begin
         last_acc = e;
         rd_bursts++;
         flp = flip_burst(rd_bursts);
         for (int k = 1; k < RD_LATENCY; k++) begin
            tick();
            chk_b("rd_early_valid", bus.rd_data_valid, 1'b0);
         end
         for (int b = 0; b < 4; b++) begin
            tick();
            exp = model[idx(a, b)];
            if (flp && b == 0) exp[0] = ~exp[0];
            chk_b("rd_valid", bus.rd_data_valid, 1'b1);
            chk("rd_data", bus.rd_data, exp);
         end
         tick();
         chk_b("rd_valid_end", bus.rd_data_valid, 1'b0);
         chk("rd_data_hold", bus.rd_data, exp);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      beat_t exp;
      rst_n = 1'b0;
      bus.cmd = 1'b0;
      bus.cmd_en = 1'b0;
      bus.addr = '0;
      bus.wr_data = '0;
      bus.data_mask = '0;
      cyc = 0;
      do_reset(3);

      // command before init is dropped
      wait_edge(10);
      for (int b = 0; b < 4; b++) begin wd[b] = rand_beat(); wm[b] = '0; end
      do_write(21'h7);

      wait_edge(INIT_CYCLES);
      chk_b("init_before", bus.init_calib, 1'b0);
      tick();
      chk_b("init_at", bus.init_calib, 1'b1);

      // basic write/read with A0..A3 beats
      wait_edge(INIT_CYCLES + 1);
      for (int b = 0; b < 4; b++) begin
         wd[b] = rand_beat();
         wd[b][7:0] = 8'hA0 + 8'(b);
         wm[b] = '0;
      end
      do_write(21'h5);
      wait_edge(last_acc + CMD_INTERVAL);
      do_read(21'h5);

      // byte mask
      wait_edge(last_acc + CMD_INTERVAL);
      for (int b = 0; b < 4; b++) begin wd[b] = '1; wm[b] = '0; end
      do_write(21'h2);
      wait_edge(last_acc + CMD_INTERVAL);
      for (int b = 0; b < 4; b++) begin wd[b] = '0; wm[b] = 16'hFFFE; end
      do_write(21'h2);
      wait_edge(last_acc + CMD_INTERVAL);
      do_read(21'h2);

      // interval violation, then aliasing
      wait_edge(last_acc + CMD_INTERVAL);
      for (int b = 0; b < 4; b++) begin wd[b] = rand_beat(); wm[b] = '0; end
      do_write(21'h100);
      wait_edge(last_acc + 5);
      do_read(21'h100);
      wait_edge(last_acc + CMD_INTERVAL);
      do_read(21'h000);

      for (int l = 0; l < 2; l++) begin
         wait_edge(last_acc + CMD_INTERVAL);
         for (int b = 0; b < 4; b++) begin wd[b] = rand_beat(); wm[b] = '0; end
         do_write(l == 0 ? 21'h7 : 21'h1);
      end

      // randomized mix including occasional interval violations
      for (int it = 0; it < 16; it++) begin
         int tgt;
         logic [AWID-1:0] a;
         a = AWID'($urandom);
         a[MEM_AW-3:0] = (MEM_AW-2)'(lines[$urandom_range(0, 4)]);
         if ($urandom_range(0, 3) == 0) tgt = last_acc + int'($urandom_range(4, CMD_INTERVAL - 1));
         else tgt = last_acc + CMD_INTERVAL + int'($urandom_range(0, 3));
         if (tgt < cyc + 1) tgt = cyc + 1;
         wait_edge(tgt);
         if ($urandom_range(0, 1) == 1) begin
            for (int b = 0; b < 4; b++) begin wd[b] = rand_beat(); wm[b] = MW'($urandom); end
            do_write(a);
         end else begin
            do_read(a);
         end
      end

      // reset in the middle of a read burst
      wait_edge(last_acc + CMD_INTERVAL);
      e = cyc + 1;
      bus.cmd_en = 1'b1;
      bus.cmd = 1'b0;
      bus.addr = 21'h5;
      tick();
      bus.cmd_en = 1'b0;
      last_acc = e;
      rd_bursts++;
      while (cyc < e + RD_LATENCY) tick();
      exp = model[idx(21'h5, 0)];
      if (flip_burst(rd_bursts)) exp[0] = ~exp[0];
      chk_b("mid_valid", bus.rd_data_valid, 1'b1);
      chk("mid_data", bus.rd_data, exp);
      rst_n = 1'b0;
      tick();
      chk_b("mid_rst_valid", bus.rd_data_valid, 1'b0);
      do_reset(1);
      for (int k = 0; k < 12; k++) begin
         tick();
         chk_b("post_rst_valid", bus.rd_data_valid, 1'b0);
      end

      // dropped write before re-init must leave old data in place
      wait_edge(20);
      for (int b = 0; b < 4; b++) begin wd[b] = rand_beat(); wm[b] = '0; end
      do_write(21'h2);
      wait_edge(INIT_CYCLES + 1);
      do_read(21'h2);

      for (int n = 0; n < 8; n++) begin
         wait_edge(last_acc + CMD_INTERVAL);
         do_read(AWID'(lines[n % 5]));
      end

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
